// File: rtl/cmd_frame_pkg.sv
// Shared constants and state encodings for the command frame receiver.
// Defining CMD_CHECKSUM_EN adds the GET_CHK parser state and the checksum helper.
package cmd_frame_pkg;

    localparam logic [7:0] HEADER_DEF = 8'hA5;
    localparam int         OP_W       = 3;

    typedef enum logic [2:0] {
        P_HUNT,
        P_GET_OP,
        P_GET_A,
        P_GET_B
`ifdef CMD_CHECKSUM_EN
        ,
        P_GET_CHK
`endif
    } parser_state_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_WAIT_HIGH
    } rx_state_t;

`ifdef CMD_CHECKSUM_EN
    function automatic logic [7:0] frame_chk(input logic [7:0] op_byte,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
        return op_byte ^ a ^ b;
    endfunction
`endif

endpackage

// File: rtl/cmd_frame_rx_if.sv
// Decoded command bundle from cmd_frame_rx to the ALU/FSM operand inputs.
// master drives the bundle, slave consumes it.
interface cmd_frame_rx_if;
    import cmd_frame_pkg::*;

    logic [7:0]      a;
    logic [7:0]      b;
    logic [OP_W-1:0] opcode;
    logic            cmd_valid;
    logic            frame_err;

    modport master (output a, b, opcode, cmd_valid, frame_err);
    modport slave  (input  a, b, opcode, cmd_valid, frame_err);

endinterface

// File: rtl/cmd_frame_rx_uart_rx_byte.sv
// 8N1 LSB-first byte receiver on an already synchronized line.
// Outputs are registered; a low stop bit gives stop_err and waits for the line to idle.
module uart_rx_byte
    import cmd_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_sync,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       stop_err
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             valid_q;
    logic             err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= R_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                R_IDLE: begin
                    if (!rx_sync) begin
                        state_q <= R_START;
                        cnt_q   <= '0;
                    end
                end
                // Mid-start-bit recheck rejects glitches shorter than half a bit.
                R_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_q <= R_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_sync) begin
                            valid_q <= 1'b1;
                            state_q <= R_IDLE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= R_WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                R_WAIT_HIGH: begin
                    if (rx_sync) begin
                        state_q <= R_IDLE;
                    end
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

    assign byte_out   = shift_q;
    assign byte_valid = valid_q;
    assign stop_err   = err_q;

endmodule

// File: rtl/cmd_frame_rx.sv
// Serial command frame receiver: HEADER, opcode, a, b bytes -> registered command bundle.
// Define CMD_CHECKSUM_EN to require a trailing XOR checksum byte.
module cmd_frame_rx
    import cmd_frame_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] HEADER       = HEADER_DEF
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           ena,
    input  logic           rx,
    cmd_frame_rx_if.master cmd
);

    logic [1:0] sync_q;
    logic       rx_sync;
    logic       rx_rst;
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       stop_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_sync = sync_q[1];
    // Holding the receiver in reset while disabled drops any partial byte silently.
    assign rx_rst  = reset | ~ena;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock     (clock),
        .reset     (rx_rst),
        .rx_sync   (rx_sync),
        .byte_out  (rx_byte),
        .byte_valid(byte_valid),
        .stop_err  (stop_err)
    );

    parser_state_t   pstate_q;
    logic [OP_W-1:0] op_pend_q;
    logic [7:0]      a_pend_q;
    logic [7:0]      a_q;
    logic [7:0]      b_q;
    logic [OP_W-1:0] op_q;
    logic            cmd_valid_q;
    logic            frame_err_q;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]      op_byte_q;
    logic [7:0]      b_pend_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            pstate_q    <= P_HUNT;
            op_pend_q   <= '0;
            a_pend_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef CMD_CHECKSUM_EN
            op_byte_q   <= '0;
            b_pend_q    <= '0;
`endif
        end else begin
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (!ena) begin
                pstate_q <= P_HUNT;
            end else if (stop_err) begin
                frame_err_q <= 1'b1;
                pstate_q    <= P_HUNT;
            end else if (byte_valid) begin
                case (pstate_q)
                    P_HUNT: begin
                        if (rx_byte == HEADER) begin
                            pstate_q <= P_GET_OP;
                        end
                    end
                    P_GET_OP: begin
                        op_pend_q <= rx_byte[OP_W-1:0];
`ifdef CMD_CHECKSUM_EN
                        op_byte_q <= rx_byte;
`endif
                        pstate_q  <= P_GET_A;
                    end
                    P_GET_A: begin
                        a_pend_q <= rx_byte;
                        pstate_q <= P_GET_B;
                    end
`ifdef CMD_CHECKSUM_EN
                    P_GET_B: begin
                        b_pend_q <= rx_byte;
                        pstate_q <= P_GET_CHK;
                    end
                    P_GET_CHK: begin
                        if (rx_byte == frame_chk(op_byte_q, a_pend_q, b_pend_q)) begin
                            a_q         <= a_pend_q;
                            b_q         <= b_pend_q;
                            op_q        <= op_pend_q;
                            cmd_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        pstate_q <= P_HUNT;
                    end
`else
                    P_GET_B: begin
                        a_q         <= a_pend_q;
                        b_q         <= rx_byte;
                        op_q        <= op_pend_q;
                        cmd_valid_q <= 1'b1;
                        pstate_q    <= P_HUNT;
                    end
`endif
                    default: pstate_q <= P_HUNT;
                endcase
            end
        end
    end

    assign cmd.a         = a_q;
    assign cmd.b         = b_q;
    assign cmd.opcode    = op_q;
    assign cmd.cmd_valid = cmd_valid_q;
    assign cmd.frame_err = frame_err_q;

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Directed bench for cmd_frame_rx: serial frames in, decoded command and pulse counts checked.
// Works in both builds; with CMD_CHECKSUM_EN a checksum byte is appended to each frame.
module tb_cmd_frame_rx;

    localparam int CPB = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ena   = 1'b1;
    logic rx    = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int n_both   = 0;

    cmd_frame_rx_if cmd();

    cmd_frame_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ena  (ena),
        .rx   (rx),
        .cmd  (cmd)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (cmd.cmd_valid) n_valid++;
        if (cmd.frame_err) n_err++;
        if (cmd.cmd_valid && cmd.frame_err) n_both++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clock);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clock);
        rx = 1'b1;
        if (!stop_bit) repeat (CPB) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        send_byte(8'hA5, 1'b1);
        send_byte(op, 1'b1);
        send_byte(a, 1'b1);
        send_byte(b, 1'b1);
`ifdef CMD_CHECKSUM_EN
        send_byte(op ^ a ^ b, 1'b1);
`endif
        repeat (4) @(negedge clock);
    endtask

    task automatic check_out(input string tag, input logic [2:0] op,
                             input logic [7:0] a, input logic [7:0] b);
        check_eq({tag, "_op"}, 32'(cmd.opcode), 32'(op));
        check_eq({tag, "_a"},  32'(cmd.a),      32'(a));
        check_eq({tag, "_b"},  32'(cmd.b),      32'(b));
    endtask

    task automatic check_pulses(input string tag, input int v0, input int e0,
                                input int dv, input int de);
        check_eq({tag, "_nvalid"}, 32'(n_valid - v0), 32'(dv));
        check_eq({tag, "_nerr"},   32'(n_err - e0),   32'(de));
    endtask

    initial begin
        int v0;
        int e0;

        repeat (3) @(negedge clock);
        check_out("rst", 3'd0, 8'h00, 8'h00);
        check_eq("rst_cmd_valid", 32'(cmd.cmd_valid), 32'd0);
        check_eq("rst_frame_err", 32'(cmd.frame_err), 32'd0);
        check_eq("rst_sync", 32'(dut.sync_q), 32'h3);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        v0 = n_valid; e0 = n_err;
        send_frame(8'h02, 8'h12, 8'h34);
        check_pulses("happy", v0, e0, 1, 0);
        check_out("happy", 3'd2, 8'h12, 8'h34);

        v0 = n_valid; e0 = n_err;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_frame(8'h05, 8'h01, 8'h02);
        check_pulses("garbage", v0, e0, 1, 0);
        check_out("garbage", 3'd5, 8'h01, 8'h02);

        v0 = n_valid; e0 = n_err;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h44, 1'b0);
        repeat (4) @(negedge clock);
        check_pulses("ferr", v0, e0, 0, 1);
        check_out("ferr_hold", 3'd5, 8'h01, 8'h02);

        v0 = n_valid; e0 = n_err;
        send_frame(8'h07, 8'hAB, 8'hCD);
        check_pulses("after_ferr", v0, e0, 1, 0);
        check_out("after_ferr", 3'd7, 8'hAB, 8'hCD);

        v0 = n_valid; e0 = n_err;
        send_frame(8'hA5, 8'hA5, 8'hA5);
        check_pulses("hdr_data", v0, e0, 1, 0);
        check_out("hdr_data", 3'd5, 8'hA5, 8'hA5);

        v0 = n_valid; e0 = n_err;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        ena = 1'b0;
        send_byte(8'h22, 1'b1);
        ena = 1'b1;
        repeat (4) @(negedge clock);
        send_byte(8'h33, 1'b1);
        repeat (4) @(negedge clock);
        check_pulses("ena_abort", v0, e0, 0, 0);
        check_out("ena_abort", 3'd5, 8'hA5, 8'hA5);

`ifdef CMD_CHECKSUM_EN
        v0 = n_valid; e0 = n_err;
        send_frame(8'h01, 8'h0F, 8'hF0);
        check_pulses("chk_good", v0, e0, 1, 0);
        check_out("chk_good", 3'd1, 8'h0F, 8'hF0);

        v0 = n_valid; e0 = n_err;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h0F, 1'b1);
        send_byte(8'hF0, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clock);
        check_pulses("chk_bad", v0, e0, 0, 1);
        check_out("chk_bad", 3'd1, 8'h0F, 8'hF0);
`endif

        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_out("rst_mid", 3'd0, 8'h00, 8'h00);
        check_eq("rst_mid_cmd_valid", 32'(cmd.cmd_valid), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        v0 = n_valid; e0 = n_err;
        send_frame(8'h04, 8'h56, 8'h78);
        check_pulses("after_rst", v0, e0, 1, 0);
        check_out("after_rst", 3'd4, 8'h56, 8'h78);

        v0 = n_valid; e0 = n_err;
        rx = 1'b0;
        repeat (CPB / 2 - 1) @(negedge clock);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        check_pulses("glitch", v0, e0, 0, 0);
        check_out("glitch", 3'd4, 8'h56, 8'h78);

        v0 = n_valid; e0 = n_err;
        send_frame(8'h06, 8'h9A, 8'hBC);
        check_pulses("final", v0, e0, 1, 0);
        check_out("final", 3'd6, 8'h9A, 8'hBC);

        check_eq("no_overlap", 32'(n_both), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_frame_rx.md
CMD_FRAME_RX -- requirements
Module: cmd_frame_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal values are 4 or more.
REQ-002 Parameter HEADER, default 8'hA5, frame start byte.
REQ-003 clock  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ena  input  1  enable; while low, the block SHALL hold the parser in HUNT and ignore rx.
REQ-006 rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 a  output  8  operand A of the last accepted frame.
REQ-008 b  output  8  operand B of the last accepted frame.
REQ-009 opcode  output  3  opcode of the last accepted frame.
REQ-010 cmd_valid  output  1  one-cycle pulse when a, b and opcode are updated.
REQ-011 frame_err  output  1  one-cycle pulse on a framing (stop-bit) error or a checksum error.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-013 Byte receiver, start detection: in IDLE, a synchronized low SHALL start reception.
REQ-014 Start-bit check: the receiver SHALL re-check the start bit at CLKS_PER_BIT/2; if it is high, the receiver SHALL return to IDLE without emitting a byte.
REQ-015 Data bits: the receiver SHALL sample 8 data bits, each CLKS_PER_BIT cycles after the previous sample point.
REQ-016 Stop bit: the receiver SHALL sample the stop bit CLKS_PER_BIT cycles after the last data bit.
REQ-017 Byte out: on a high stop bit, the receiver SHALL emit byte_valid for 1 cycle with the assembled byte.
REQ-018 Framing error: on a low stop bit, the receiver SHALL pulse frame_err, emit no byte, reset the parser to HUNT, and wait for rx high before returning to IDLE.
REQ-019 Parser states SHALL be HUNT, GET_OP, GET_A, GET_B and (when REQ-030 applies) GET_CHK.
REQ-020 HUNT: a byte equal to HEADER SHALL move the parser to GET_OP; any other byte SHALL be discarded.
REQ-021 GET_OP: the parser SHALL latch byte[2:0] as the pending opcode, discard byte[7:3], and move to GET_A.
REQ-022 GET_A: the parser SHALL latch the byte as pending a and move to GET_B.
REQ-023 GET_B: the parser SHALL latch the byte as pending b, then commit the frame, or move to GET_CHK under REQ-030.
REQ-024 Commit: a, b and opcode SHALL update and cmd_valid SHALL pulse in the cycle after the final byte_valid; the parser SHALL then return to HUNT.
REQ-025 a, b and opcode SHALL hold their values between commits; a partial or erroneous frame SHALL never alter them.
REQ-026 A HEADER byte received in GET_OP, GET_A or GET_B SHALL be treated as data, not as a resync.
REQ-027 Deasserting ena mid-frame SHALL abort the frame, with no commit and no error pulse.
REQ-028 cmd_valid and frame_err SHALL never be asserted in the same cycle.

Reset
REQ-029 On reset, a, b and opcode SHALL be 0, cmd_valid and frame_err SHALL be 0, the parser SHALL be in HUNT, the receiver SHALL be in IDLE, and both synchronizer flops SHALL be 1.

Configuration
REQ-030 With CMD_CHECKSUM_EN defined, a GET_CHK state SHALL follow GET_B. A byte equal to the XOR of the opcode byte, a and b SHALL commit the frame; any other value SHALL pulse frame_err with no commit. In both cases the parser SHALL return to HUNT. Without the macro, a frame is 4 bytes and GET_CHK SHALL NOT exist.

Structure
REQ-031 Package cmd_frame_pkg SHALL hold the HEADER default, the parser state encoding, the receiver state encoding and the opcode width (3).
REQ-032 The byte receiver SHALL be a sub-module, uart_rx_byte (ports: clock, reset, rx_sync, byte_out, byte_valid, stop_err); cmd_frame_rx SHALL instantiate it once.
REQ-033 cmd_frame_rx outputs SHALL be registered so they can connect directly to the ALU/FSM operand inputs.

Verification
REQ-034 Happy path: send A5 02 12 34, no checksum -> exactly one cmd_valid; opcode=2, a=8'h12, b=8'h34.
REQ-035 Garbage before header: send 00 FF A5 05 01 02 -> one cmd_valid; opcode=5, a=1, b=2.
REQ-036 Framing error: a byte with a low stop bit inside a frame -> frame_err pulse, no cmd_valid, outputs unchanged; the next good frame is accepted.
REQ-037 Checksum build: send A5 01 0F F0 with checksum FE -> commit; the same frame with checksum 00 -> frame_err, outputs unchanged.
REQ-038 Reset mid-frame: reset after A5 03 -> all outputs 0; a subsequent full frame commits correctly.
REQ-039 Glitch rejection: a low pulse shorter than CLKS_PER_BIT/2 on idle rx -> no byte, no pulses.
